uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8N1, 16x-clocked serial receiver feeding the CPU's UART controller.
- Adds configurable data width, oversample ratio, parity and stop bits, plus a sample-tick enable so the block can run from the system clock.
- Adds start-bit glitch rejection, parity/framing/break flags, and a busy indication.
- Output interface stays a one-clock valid pulse (rx_status) with held data (rx_data), matching what the UART controller already consumes.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first.
- OVERSAMPLE, 16, sample ticks per bit, even, legal 4..64.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked, legal 1 or 2.

Ports:
- clk  input  1  block clock.
- reset  input  1  asynchronous active-high reset.
- sample_tick  input  1  oversample enable; tie to 1 when clk already runs at OVERSAMPLE x baud.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last received word, held until the next completed frame.
- rx_status  output  1  one-clk pulse: frame complete, rx_data and flags valid.
- rx_parity_err  output  1  parity mismatch on last frame; always 0 when PARITY=0.
- rx_frame_err  output  1  a checked stop bit sampled 0 on last frame.
- rx_break  output  1  last frame was a break condition.
- rx_busy  output  1  high from start detection until return to IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values: rx_data all ones; rx_status, rx_parity_err, rx_frame_err, rx_break and rx_busy all 0; state IDLE; line history 1.
- Input synchroniser: uart_rx passes through 2 flops, reset to 1; all decisions use the synchronised value.
- Timing gate: state and counters advance only on clk edges where sample_tick=1. rx_status, however, is exactly one clk wide regardless of sample_tick.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE -> START: on a tick where the previous sampled value is 1 and the current one is 0. Call this tick T0. rx_busy rises the next clk.
- START: at tick T0+OVERSAMPLE/2, the line is re-sampled.
  - If it reads 1 (glitch): go back to IDLE, no rx_status, all flags unchanged.
  - If it reads 0: enter DATA.
- DATA: bit i is sampled at tick T0 + OVERSAMPLE/2 + (i+1)*OVERSAMPLE, for i = 0..DATA_BITS-1. Bits shift into a holding register LSB first.
- PARITY (PARITY != 0 only): one further bit period.
  - Odd mode: error if data XOR parity bit = 0.
  - Even mode: error if data XOR parity bit = 1.
- STOP: STOP_BITS consecutive bit periods. rx_frame_err = 1 if any stop sample is 0.
- Completion: on the clk after the final stop sample, the block does all of the following in the same clk:
  - updates rx_data, rx_parity_err, rx_frame_err and rx_break;
  - pulses rx_status for one clk.
- Next state after completion:
  - Stop bits good: go to IDLE; rx_busy falls with the pulse.
  - Frame error: go to WAIT_IDLE.
- Break: rx_break = 1 when all data bits, the parity bit (if present) and the first stop bit are 0. rx_frame_err is also 1 in that case.
- WAIT_IDLE: stays until one tick samples 1, then goes to IDLE. A held-low line therefore produces exactly one frame report.
- Flags and rx_data are only ever written together with rx_status; they hold between frames.
- Back-to-back frames: a start edge is accepted on the first tick after returning to IDLE. No idle gap beyond the stop bit(s) is required.
- Reset mid-frame: immediate return to IDLE, no rx_status, partial data discarded, outputs take their reset values.
- Counters: bit counter is $clog2(DATA_BITS+1) wide; tick counter is $clog2(OVERSAMPLE) wide; both wrap only under FSM control.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each start, data, parity and stop decision is the 2-of-3 majority of samples at mid-1, mid and mid+1 ticks. The decision is taken at mid+1, so the completion pulse moves one tick later.
- Undefined: a single sample at the mid tick, as specified above.

Test Plan:
- 8N1, OVERSAMPLE=16, sample_tick=1, send 0x55 -> rx_data=0x55, rx_status high exactly 1 clk, 150-156 clk after uart_rx falls, all flags 0.
- Same config, 4-clk low glitch on idle line -> no rx_status, rx_busy returns 0 within 12 clk, rx_data stays 0xFF.
- PARITY=2, send 0xA3 with parity bit 1 (wrong; correct bit is 0) -> rx_data=0xA3, rx_parity_err=1; then correct frame 0xA3 -> rx_parity_err=0.
- 8N1, send 0x3C with stop bit 0 -> rx_frame_err=1, rx_break=0; line then held high -> next frame 0x81 received cleanly.
- Line held low for 20 bit times, then released -> exactly one rx_status, rx_data=0x00, rx_frame_err=1, rx_break=1.
- sample_tick asserted every 4th clk, two back-to-back frames 0x12, 0x34 -> two single-clk pulses with correct data; assert reset mid-second frame -> no pulse, outputs at reset values.

Source files
------------

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with parity/framing/break flags
// Optional UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote over mid-1/mid/mid+1, taken at mid+1.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_DEC = OVERSAMPLE / 2;
`else
  localparam int START_DEC = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [CW-1:0] START_LAST = CW'(START_DEC);
  localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
  } state_t;

  state_t               state, state_n;
  logic                 sync1, sync2, prev;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit, stop_err, first_stop, done;
  logic                 bit_val, start_end, bit_end;
  logic                 data_par, par_err, brk;

  assign start_end = sample_tick && (tick_cnt == START_LAST);
  assign bit_end   = sample_tick && (tick_cnt == BIT_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic s_a, s_b;

  // Two-tick history so the decision tick sees mid-1, mid and mid+1 together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (sample_tick) begin
      s_a <= s_b;
      s_b <= sync2;
    end
  end

  assign bit_val = (s_a & s_b) | (s_a & sync2) | (s_b & sync2);
`else
  assign bit_val = sync2;
`endif

  assign data_par = (^shift) ^ par_bit;
  assign par_err  = (PARITY == 1) ? ~data_par : (PARITY == 2) ? data_par : 1'b0;
  assign brk      = (shift == '0) && ((PARITY == 0) || !par_bit) && !first_stop;
  assign rx_busy  = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (sample_tick && prev && !sync2) state_n = ST_START;
      ST_START:     if (start_end) state_n = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_end && (bit_cnt == DATA_LAST))
                      state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_end) state_n = ST_STOP;
      ST_STOP:      if (done) state_n = stop_err ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: if (sample_tick && sync2) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      prev          <= 1'b1;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      par_bit       <= 1'b0;
      stop_err      <= 1'b0;
      first_stop    <= 1'b1;
      done          <= 1'b0;
      rx_data       <= '1;
      rx_status     <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      sync1     <= uart_rx;
      sync2     <= sync1;
      rx_status <= 1'b0;
      if (sample_tick) prev <= sync2;
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          stop_err <= 1'b0;
          done     <= 1'b0;
        end
        ST_START: begin
          if (sample_tick) tick_cnt <= start_end ? '0 : tick_cnt + 1'b1;
        end
        ST_DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            shift    <= {bit_val, shift[DATA_BITS-1:1]};
            bit_cnt  <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tick_cnt <= '0;
            par_bit  <= bit_val;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Completion fires on the clk after the last stop sample, tick or not
          if (done) begin
            done          <= 1'b0;
            rx_status     <= 1'b1;
            rx_data       <= shift;
            rx_parity_err <= par_err;
            rx_frame_err  <= stop_err;
            rx_break      <= brk;
          end else if (bit_end) begin
            tick_cnt <= '0;
            if (!bit_val) stop_err <= 1'b1;
            if (bit_cnt == '0) first_stop <= bit_val;
            if (bit_cnt == STOP_LAST) done <= 1'b1;
            else                      bit_cnt <= bit_cnt + 1'b1;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized and directed bench for uart_rx_param (8N1 and 8E2 instances)
module tb_uart_rx_param;
  logic clk = 1'b0, reset = 1'b1, sample_tick = 1'b1, rx0 = 1'b1, rx1 = 1'b1;
  logic [7:0] d0, d1;
  logic st0, st1, pe0, pe1, fe0, fe1, bk0, bk1, busy0, busy1;
  int checks = 0, errors = 0;
  int cyc = 0, tick_div = 1, tcnt = 0;

  typedef struct {
    logic [7:0] d;
    logic pe, fe, bk;
    int cyc;
  } rep_t;

  rep_t q0[$], q1[$];
  int run0 = 0, run1 = 0, max0 = 0, max1 = 0;

  always #5 clk = ~clk;

  uart_rx_param dut0 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .uart_rx(rx0),
    .rx_data(d0), .rx_status(st0), .rx_parity_err(pe0), .rx_frame_err(fe0),
    .rx_break(bk0), .rx_busy(busy0));

  uart_rx_param #(.PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .uart_rx(rx1),
    .rx_data(d1), .rx_status(st1), .rx_parity_err(pe1), .rx_frame_err(fe1),
    .rx_break(bk1), .rx_busy(busy1));

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    tcnt++;
    sample_tick = (tick_div == 1) || (tcnt % tick_div == 0);
  end

  // Report collector: one entry per clk that rx_status is high, plus longest pulse run
  always @(negedge clk) begin
    if (st0) q0.push_back('{d0, pe0, fe0, bk0, cyc});
    if (st1) q1.push_back('{d1, pe1, fe1, bk1, cyc});
    run0 = st0 ? run0 + 1 : 0;
    run1 = st1 ? run1 + 1 : 0;
    if (run0 > max0) max0 = run0;
    if (run1 > max1) max1 = run1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial frame: start 0, data LSB first, optional parity, stop bits (first forced low on stop_bad)
  function automatic logic [15:0] build(input logic [7:0] w, input int pmode, input logic pbit,
                                        input int nstop, input logic stop_bad, output int n);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = w[i];
    n = 9;
    if (pmode != 0) begin
      f[n] = pbit;
      n++;
    end
    f[n] = !stop_bad;
    n = n + nstop;
    return f;
  endfunction

  function automatic rep_t model(input logic [7:0] w, input int pmode, input logic pbit,
                                 input logic stop_bad);
    rep_t r;
    int ones;
    ones  = $countones(w) + ((pmode != 0 && pbit) ? 1 : 0);
    r.d   = w;
    r.pe  = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
    r.fe  = stop_bad;
    r.bk  = (w == 8'h00) && (pmode == 0 || !pbit) && stop_bad;
    r.cyc = 0;
    return r;
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic send(input int which, input logic [15:0] f, input int n, input int cpb);
    for (int i = 0; i < n; i++) begin
      set_line(which, f[i]);
      repeat (cpb) @(posedge clk);
      #1;
    end
    set_line(which, 1'b1);
  endtask

  function automatic int qsize(input int which);
    return (which == 0) ? q0.size() : q1.size();
  endfunction

  task automatic expect_rep(input int which, input string tag, input rep_t e, output rep_t r);
    int n = 0;
    r = '{8'h00, 1'b0, 1'b0, 1'b0, 0};
    while (qsize(which) == 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_present"}, qsize(which) != 0, 1);
    if (qsize(which) != 0) begin
      if (which == 0) r = q0.pop_front();
      else            r = q1.pop_front();
      check({tag, "_data"}, r.d, e.d);
      check({tag, "_perr"}, r.pe, e.pe);
      check({tag, "_ferr"}, r.fe, e.fe);
      check({tag, "_break"}, r.bk, e.bk);
    end
  endtask

  task automatic frame(input int which, input logic [7:0] w, input logic pbit, input logic stop_bad,
                       input int cpb, input string tag, output rep_t r);
    int n;
    logic [15:0] f;
    rep_t e;
    int pm = (which == 0) ? 0 : 2;
    int ns = (which == 0) ? 1 : 2;
    f = build(w, pm, pbit, ns, stop_bad, n);
    e = model(w, pm, pbit, stop_bad);
    send(which, f, n, cpb);
    expect_rep(which, tag, e, r);
  endtask

  initial begin
    rep_t r;
    int fall, n;
    logic [15:0] f;
    logic [7:0] w;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data0", d0, 8'hFF);
    check("rst_data1", d1, 8'hFF);
    check("rst_outs0", {st0, pe0, fe0, bk0, busy0}, 5'b0);
    check("rst_outs1", {st1, pe1, fe1, bk1, busy1}, 5'b0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Short low glitch on an idle line is rejected at the start-bit re-sample
    rx0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("glitch_busy_rise", busy0, 1'b1);
    rx0 = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("glitch_busy_fall", busy0, 1'b0);
    check("glitch_no_report", q0.size(), 0);
    check("glitch_data_held", d0, 8'hFF);
    repeat (20) @(posedge clk);
    #1;

    fall = cyc;
    frame(0, 8'h55, 1'b0, 1'b0, 16, "f55", r);
    check("f55_latency_ok", (r.cyc - fall >= 150) && (r.cyc - fall <= 156), 1);
    repeat (16) @(posedge clk);
    #1;

    frame(1, 8'hA3, 1'b1, 1'b0, 16, "a3_badpar", r);
    frame(1, 8'hA3, 1'b0, 1'b0, 16, "a3_goodpar", r);

    frame(0, 8'h3C, 1'b0, 1'b1, 16, "f3c_stop0", r);
    repeat (32) @(posedge clk);
    #1;
    frame(0, 8'h81, 1'b0, 1'b0, 16, "f81_after", r);

    // Held-low line: one break report, then WAIT_IDLE until released
    rx0 = 1'b0;
    repeat (320) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("break_one_report", q0.size(), 1);
    check("break_busy_low", busy0, 1'b0);
    expect_rep(0, "break", model(8'h00, 0, 1'b0, 1'b1), r);

    for (int i = 0; i < 12; i++) begin
      logic sb, pb;
      w  = 8'($urandom);
      sb = ($urandom % 4) == 0;
      pb = 1'($urandom);
      frame(0, w, 1'b0, sb, 16, "rnd0", r);
      if (sb || ($urandom % 2) == 1) begin
        repeat (16) @(posedge clk);
        #1;
      end
      w  = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
      frame(1, w, pb, sb, 16, "rnd1", r);
      if (sb) begin
        repeat (16) @(posedge clk);
        #1;
      end
    end
    repeat (32) @(posedge clk);
    #1;
    check("rnd_no_extra0", q0.size(), 0);
    check("rnd_no_extra1", q1.size(), 0);

    // Divided tick: back-to-back frames, then reset in the middle of a third
    tick_div = 4;
    repeat (8) @(posedge clk);
    #1;
    frame(0, 8'h12, 1'b0, 1'b0, 64, "tick4_12", r);
    frame(0, 8'h34, 1'b0, 1'b0, 64, "tick4_34", r);
    f = build(8'h56, 0, 1'b0, 1, 1'b0, n);
    send(0, f, 4, 64);
    check("midframe_busy", busy0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrst_data", d0, 8'hFF);
    check("midrst_outs", {st0, pe0, fe0, bk0, busy0}, 5'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (800) @(posedge clk);
    #1;
    check("midrst_no_report", q0.size(), 0);
    check("midrst_data_held", d0, 8'hFF);

    check("pulse_width0", max0, 1);
    check("pulse_width1", max1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
